hpi_access_sequencer: RTL and testbench
=======================================

# hpi_access_sequencer

Transaction sequencer that sits directly upstream of the CY7C67200 HPI interface stage and drives its host-side strobes. It converts CY16 memory read and write bursts, plus single HPI register accesses, into timed ADDRESS-register and DATA-register cycles. Pulse and recovery widths are parameterised. It consumes the interface stage's registered read data and interrupt.

## Interface
- STROBE_CYCLES, 4: cycles oHPI_CS_N and oHPI_RD_N/oHPI_WR_N are held low per access (≥1).
- RECOVERY_CYCLES, 2: idle cycles after each strobe (≥2, required for read-data capture).
- iCLK  in  1  system clock.
- iRST  in  1  asynchronous, active-high reset.
- iCMD_VALID / oCMD_READY  in/out  1  command handshake.
- iCMD_WE  in  1  1 = write, 0 = read.
- iCMD_REG  in  1  1 = single HPI register access at iCMD_ADDR[1:0]; 0 = memory burst.
- iCMD_ADDR  in  16  CY16 byte address, or the register index in bits [1:0].
- iCMD_LEN  in  8  burst words minus one (0 → 1 word, 255 → 256 words); ignored when iCMD_REG=1.
- iWD_VALID / oWD_READY  in/out  1 / 1  write-data handshake.
- iWD_DATA  in  16  write word.
- oRD_VALID / iRD_READY  out/in  1 / 1  read-data handshake.
- oRD_DATA  out  16  read word.
- oBUSY  out  1  high from command accept until DONE.
- oIRQ  out  1  interrupt indication (see Configuration).
- iIRQ_CLR  in  1  clears the latched interrupt.
- oHPI_DATA  out  32  write data to the interface stage; [31:16] = 0.
- oHPI_ADDR  out  2  HPI register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- oHPI_RD_N, oHPI_WR_N, oHPI_CS_N  out  1  active-low strobes.
- iHPI_DATA  in  32  registered read data from the interface stage; [15:0] are used.
- iHPI_INT  in  1  registered HPI interrupt.

## Operation
- Reset values:
  - Strobes = 1; oHPI_ADDR = 0; oHPI_DATA = 0.
  - oCMD_READY = 0, oWD_READY = 0, oRD_VALID = 0.
  - oRD_DATA = 0; oBUSY = 0; oIRQ = 0.
  - FSM = IDLE; word counter = 0.
- Reset asserted mid-operation aborts immediately: strobes go high asynchronously and pending data is discarded.
- Each access is three phases:
  - SETUP, 1 cycle: oHPI_ADDR and oHPI_DATA driven, strobes high.
  - STROBE, STROBE_CYCLES: oHPI_CS_N low, plus oHPI_WR_N or oHPI_RD_N low.
  - RECOVERY, RECOVERY_CYCLES: strobes high; oHPI_ADDR and oHPI_DATA held.
- States:
  - IDLE: oCMD_READY = 1. On accept, latch the command and set counter = iCMD_LEN. Go to REG_WAIT if iCMD_REG, else to ADDR_ACC.
  - ADDR_ACC: write iCMD_ADDR to HPI register 2, then go to DATA_WAIT.
  - DATA_WAIT:
    - Write: oWD_READY = 1 until iWD_VALID.
    - Read: proceed at once.
    - Then go to DATA_ACC.
  - DATA_ACC: access HPI register 0. Reads capture iHPI_DATA[15:0] on the edge ending the 2nd recovery cycle.
  - RD_HOLD (read only): oRD_VALID = 1 until iRD_READY.
  - Next step:
    - If counter = 0, go to DONE.
    - Otherwise decrement the counter and return to DATA_WAIT.
    - The chip auto-increments its address, so ADDRESS is never rewritten within a burst.
  - REG_WAIT / REG_ACC: the same as DATA_WAIT / DATA_ACC, but for one access to register iCMD_ADDR[1:0].
  - DONE: 1 cycle with oBUSY = 1, then IDLE.
- Commands are never accepted while oBUSY = 1.
- oRD_DATA is stable while oRD_VALID = 1 and iRD_READY = 0.

## Timing
- Single memory write, with the data word already valid: 2·(1+STROBE_CYCLES+RECOVERY_CYCLES)+3 cycles from accept to IDLE. This is 17 at the defaults.
- Read capture: the strobe is low in cycles t..t+P−1 (P = STROBE_CYCLES). The interface stage samples in cycle t+P, and its data is valid in cycle t+P+1. That is the 2nd recovery cycle, where the capture happens.
- oRD_VALID rises the cycle after capture.
- oWD_READY is high for exactly the cycle of the handshake when iWD_VALID is already high.
- Backpressure on either data handshake stalls the FSM with strobes high. No access is split.
- Burst boundary: iCMD_LEN = 255 performs exactly 256 DATA accesses, and the counter never wraps.

## Configuration
- HPI_IRQ_LATCH_EN defined:
  - oIRQ sets on a rising edge of iHPI_INT and stays set until iIRQ_CLR.
  - If iIRQ_CLR and an edge occur in the same cycle, set wins.
- Undefined: oIRQ is iHPI_INT delayed one register, and iIRQ_CLR is ignored.

## Test plan
- Reset mid-STROBE during a write → strobes go high within the same cycle; after release, oCMD_READY = 1 and no further strobe appears.
- Memory write, addr 0x1000, LEN = 0, data 0xA5C3:
  - First access: HPI_ADDR = 2, data 0x1000.
  - Second access: HPI_ADDR = 0, data 0xA5C3.
  - Each WR_N low exactly 4 cycles; 17 cycles from accept to IDLE.
- Read burst, addr 0x2000, LEN = 3, with the model returning 0x0001..0x0004 → 1 ADDRESS write and 4 DATA reads. oRD_DATA = 0x0001..0x0004 in order, including with iRD_READY toggled every other cycle.
- Register read, REG = 1, addr = 3, model status 0x8001 → a single RD_N pulse with HPI_ADDR = 3 and no ADDRESS write; oRD_DATA = 0x8001.
- Write burst of LEN = 255 with iWD_VALID gapped → 256 DATA writes and oBUSY continuous; a second command is refused until DONE.
- With HPI_IRQ_LATCH_EN: an iHPI_INT pulse of 1 cycle makes oIRQ stay 1, and iIRQ_CLR clears it. Without the macro, oIRQ follows iHPI_INT one cycle late.

Source files
------------

// File: rtl/hpi_access_sequencer.sv
`timescale 1ns/1ps
// CY16 burst/register commands -> timed HPI ADDRESS/DATA strobe cycles; define HPI_IRQ_LATCH_EN to latch oIRQ.
// Single write with data ready: 2*(1+STROBE+RECOVERY)+3 cycles; data-handshake backpressure stalls between accesses.
module hpi_access_sequencer #(
    parameter int STROBE_CYCLES   = 4,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCMD_VALID,
    output logic        oCMD_READY,
    input  logic        iCMD_WE,
    input  logic        iCMD_REG,
    input  logic [15:0] iCMD_ADDR,
    input  logic [7:0]  iCMD_LEN,
    input  logic        iWD_VALID,
    output logic        oWD_READY,
    input  logic [15:0] iWD_DATA,
    output logic        oRD_VALID,
    input  logic        iRD_READY,
    output logic [15:0] oRD_DATA,
    output logic        oBUSY,
    output logic        oIRQ,
    input  logic        iIRQ_CLR,
    output logic [31:0] oHPI_DATA,
    output logic [1:0]  oHPI_ADDR,
    output logic        oHPI_RD_N,
    output logic        oHPI_WR_N,
    output logic        oHPI_CS_N,
    input  logic [31:0] iHPI_DATA,
    input  logic        iHPI_INT
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_ACC, S_DATA_WAIT, S_DATA_ACC,
        S_RD_HOLD, S_REG_WAIT, S_REG_ACC, S_DONE
    } state_t;

    // Access phase: 0 = SETUP, 1..STROBE = strobe low, then RECOVERY cycles.
    localparam int PH_MAX = STROBE_CYCLES + RECOVERY_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH_MAX);
    localparam logic [PH_W-1:0] PH_STB  = PH_W'(STROBE_CYCLES);
    localparam logic [PH_W-1:0] PH_CAP  = PH_W'(STROBE_CYCLES + 2);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              reg_q, reg_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        hpi_addr_q, hpi_addr_d;
    logic [15:0]       hpi_data_q, hpi_data_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              step;
    logic              in_acc, stb, acc_we;
    logic              irq_q;
    logic              unused_ok;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            cnt_q      <= 8'd0;
            we_q       <= 1'b0;
            reg_q      <= 1'b0;
            idx_q      <= 2'd0;
            hpi_addr_q <= 2'd0;
            hpi_data_q <= 16'h0000;
            rd_data_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            reg_q      <= reg_d;
            idx_q      <= idx_d;
            hpi_addr_q <= hpi_addr_d;
            hpi_data_q <= hpi_data_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        reg_d      = reg_q;
        idx_d      = idx_q;
        hpi_addr_d = hpi_addr_q;
        hpi_data_d = hpi_data_q;
        rd_data_d  = rd_data_q;
        step       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (iCMD_VALID) begin
                    we_d  = iCMD_WE;
                    reg_d = iCMD_REG;
                    idx_d = iCMD_ADDR[1:0];
                    cnt_d = iCMD_LEN;
                    ph_d  = '0;
                    if (iCMD_REG) begin
                        state_d = S_REG_WAIT;
                    end else begin
                        state_d    = S_ADDR_ACC;
                        hpi_addr_d = 2'd2;
                        hpi_data_d = iCMD_ADDR;
                    end
                end
            end
            S_ADDR_ACC: begin
                if (ph_q == PH_LAST) begin
                    ph_d    = '0;
                    state_d = S_DATA_WAIT;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_DATA_WAIT, S_REG_WAIT: begin
                if (!we_q || iWD_VALID) begin
                    state_d    = (state_q == S_REG_WAIT) ? S_REG_ACC : S_DATA_ACC;
                    hpi_addr_d = (state_q == S_REG_WAIT) ? idx_q : 2'd0;
                    hpi_data_d = we_q ? iWD_DATA : 16'h0000;
                    ph_d       = '0;
                end
            end
            S_DATA_ACC, S_REG_ACC: begin
                // The interface stage's registered data is valid in the 2nd recovery cycle.
                if (!we_q && (ph_q == PH_CAP)) begin
                    rd_data_d = iHPI_DATA[15:0];
                end
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (we_q) begin
                        step = 1'b1;
                    end else begin
                        state_d = S_RD_HOLD;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_RD_HOLD: begin
                if (iRD_READY) begin
                    step = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The chip auto-increments its address, so later words skip the ADDRESS write.
        if (step) begin
            if (reg_q || (cnt_q == 8'd0)) begin
                state_d = S_DONE;
            end else begin
                cnt_d   = cnt_q - 8'd1;
                state_d = S_DATA_WAIT;
            end
        end
    end

    assign in_acc = (state_q == S_ADDR_ACC) || (state_q == S_DATA_ACC) || (state_q == S_REG_ACC);
    assign stb    = in_acc && (ph_q != '0) && (ph_q <= PH_STB);
    assign acc_we = (state_q == S_ADDR_ACC) || we_q;

    assign oHPI_CS_N  = ~stb;
    assign oHPI_WR_N  = ~(stb && acc_we);
    assign oHPI_RD_N  = ~(stb && !acc_we);
    assign oHPI_ADDR  = hpi_addr_q;
    assign oHPI_DATA  = {16'h0000, hpi_data_q};

    assign oCMD_READY = (state_q == S_IDLE) && !iRST;
    assign oWD_READY  = ((state_q == S_DATA_WAIT) || (state_q == S_REG_WAIT)) && we_q;
    assign oRD_VALID  = (state_q == S_RD_HOLD);
    assign oRD_DATA   = rd_data_q;
    assign oBUSY      = (state_q != S_IDLE);
    assign oIRQ       = irq_q;

`ifdef HPI_IRQ_LATCH_EN
    logic int_q;

    // A new interrupt edge beats a simultaneous clear.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            int_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            int_q <= iHPI_INT;
            if (iHPI_INT && !int_q) begin
                irq_q <= 1'b1;
            end else if (iIRQ_CLR) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign unused_ok = ^iHPI_DATA[31:16];
`else
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= iHPI_INT;
        end
    end

    assign unused_ok = ^{iIRQ_CLR, iHPI_DATA[31:16]};
`endif

endmodule

// File: tb/tb_hpi_access_sequencer.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for hpi_access_sequencer with a behavioural CY7C67200 HPI model.
module tb_hpi_access_sequencer;

    localparam int P = 4;
    localparam int R = 2;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iCMD_VALID, iCMD_WE, iCMD_REG;
    logic [15:0] iCMD_ADDR;
    logic [7:0]  iCMD_LEN;
    logic        iWD_VALID;
    logic [15:0] iWD_DATA;
    logic        iRD_READY;
    logic        iIRQ_CLR, iHPI_INT;
    logic [31:0] iHPI_DATA;
    logic        oCMD_READY, oWD_READY, oRD_VALID, oBUSY, oIRQ;
    logic [15:0] oRD_DATA;
    logic [31:0] oHPI_DATA;
    logic [1:0]  oHPI_ADDR;
    logic        oHPI_RD_N, oHPI_WR_N, oHPI_CS_N;

    hpi_access_sequencer #(.STROBE_CYCLES(P), .RECOVERY_CYCLES(R)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iCMD_VALID(iCMD_VALID), .oCMD_READY(oCMD_READY), .iCMD_WE(iCMD_WE), .iCMD_REG(iCMD_REG),
        .iCMD_ADDR(iCMD_ADDR), .iCMD_LEN(iCMD_LEN),
        .iWD_VALID(iWD_VALID), .oWD_READY(oWD_READY), .iWD_DATA(iWD_DATA),
        .oRD_VALID(oRD_VALID), .iRD_READY(iRD_READY), .oRD_DATA(oRD_DATA),
        .oBUSY(oBUSY), .oIRQ(oIRQ), .iIRQ_CLR(iIRQ_CLR),
        .oHPI_DATA(oHPI_DATA), .oHPI_ADDR(oHPI_ADDR),
        .oHPI_RD_N(oHPI_RD_N), .oHPI_WR_N(oHPI_WR_N), .oHPI_CS_N(oHPI_CS_N),
        .iHPI_DATA(iHPI_DATA), .iHPI_INT(iHPI_INT)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed { logic [1:0] a; logic [15:0] d; logic we; } acc_t;

    acc_t        exp_acc[$];
    logic [15:0] exp_rd[$];
    logic [15:0] wd_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        wd_hs = 1'b0;
    logic        gap_mode = 1'b0;
    int          rdy_mode = 0;
    logic [15:0] m_addr = 16'h0, m_mbox = 16'h1234;
    logic [15:0] c_addr = 16'h0, c_mbox = 16'h1234;
    logic [15:0] chip_val = 16'h0;
    logic        chip_fire = 1'b0, chip_clr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Chip memory content: a fixed pattern, word at 0x2000 is 1 and counts up.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return ((a - 16'h2000) >> 1) + 16'd1;
    endfunction

    // HPI access monitor, scoreboard and reactive chip model.
    initial begin
        logic in_stb;
        int   w, gap;
        acc_t cur, e;
        in_stb = 1'b0; w = 0; gap = 1000;
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                in_stb = 1'b0;
                gap    = 1000;
            end else if (!oHPI_CS_N) begin
                if (!in_stb) begin
                    in_stb = 1'b1;
                    w      = 1;
                    cur    = '{a: oHPI_ADDR, d: oHPI_DATA[15:0], we: !oHPI_WR_N};
                    chk("rd_wr_exclusive", 32'(oHPI_RD_N ^ oHPI_WR_N), 32'd1);
                    chk("hpi_data_hi", 32'(oHPI_DATA[31:16]), 32'd0);
                    chk("strobe_spacing_ok", 32'(gap >= R + 1), 32'd1);
                end else begin
                    w++;
                    chk("addr_hold", 32'(oHPI_ADDR), 32'(cur.a));
                    chk("data_hold", 32'(oHPI_DATA[15:0]), 32'(cur.d));
                end
            end else if (in_stb) begin
                in_stb = 1'b0;
                gap    = 1;
                chk("strobe_width", 32'(w), 32'(P));
                if (exp_acc.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_access: got reg %0d we %0b data 0x%0h, expected none", cur.a, cur.we, cur.d);
                end else begin
                    e = exp_acc.pop_front();
                    chk("acc_reg", 32'(cur.a), 32'(e.a));
                    chk("acc_dir", 32'(cur.we), 32'(e.we));
                    if (e.we) chk("acc_wdata", 32'(cur.d), 32'(e.d));
                end
                if (cur.we) begin
                    case (cur.a)
                        2'd0: c_addr = c_addr + 16'd2;
                        2'd1: c_mbox = cur.d;
                        2'd2: c_addr = cur.d;
                        default: ;
                    endcase
                end else begin
                    case (cur.a)
                        2'd0: begin chip_val = mem_word(c_addr); c_addr = c_addr + 16'd2; end
                        2'd1: chip_val = c_mbox;
                        2'd2: chip_val = c_addr;
                        default: chip_val = 16'h8001;
                    endcase
                    chip_fire = 1'b1;
                end
            end else begin
                gap++;
            end
        end
    end

    // Interface-stage read register: valid only in the 2nd recovery cycle.
    initial begin
        iHPI_DATA = 32'hFFFF_DEAD;
        forever begin
            @(posedge iCLK); #1;
            if (chip_fire) begin
                iHPI_DATA = {16'hFFFF, chip_val};
                chip_fire = 1'b0;
                chip_clr  = 1'b1;
            end else if (chip_clr) begin
                iHPI_DATA = 32'hFFFF_DEAD;
                chip_clr  = 1'b0;
            end
        end
    end

    // Read-data monitor.
    initial begin
        logic pv, pr;
        logic [15:0] pd;
        pv = 1'b0; pr = 1'b0; pd = 16'h0;
        forever begin
            @(negedge iCLK);
            if (iRST) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("rd_valid_held", 32'(oRD_VALID), 32'd1);
                    chk("rd_data_stable", 32'(oRD_DATA), 32'(pd));
                end
                if (oRD_VALID && iRD_READY) begin
                    if (exp_rd.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_read: got 0x%0h, expected none", oRD_DATA);
                    end else begin
                        chk("rd_data", 32'(oRD_DATA), 32'(exp_rd.pop_front()));
                    end
                end
                pv = oRD_VALID; pr = iRD_READY; pd = oRD_DATA;
            end
        end
    end

    // Write-data handshake observation.
    initial begin
        logic hs_prev;
        hs_prev = 1'b0;
        forever begin
            @(negedge iCLK);
            if (hs_prev) chk("wd_ready_one_cycle", 32'(oWD_READY), 32'd0);
            hs_prev = 1'b0;
            if (!iRST && oWD_READY && iWD_VALID) begin
                wd_hs   = 1'b1;
                hs_prev = 1'b1;
            end
        end
    end

    // Write-data source, optionally gapped; valid is held until taken.
    initial begin
        iWD_VALID = 1'b0; iWD_DATA = 16'h0;
        forever begin
            @(posedge iCLK); #1;
            if (wd_hs) begin
                if (wd_q.size() > 0) void'(wd_q.pop_front());
                wd_hs = 1'b0;
                iWD_VALID = 1'b0;
            end
            if (iRST) begin
                iWD_VALID = 1'b0;
            end else if (!iWD_VALID && wd_q.size() > 0 && (!gap_mode || $urandom_range(0, 2) == 0)) begin
                iWD_VALID = 1'b1;
                iWD_DATA  = wd_q[0];
            end
        end
    end

    // Read-data sink.
    initial begin
        iRD_READY = 1'b1;
        forever begin
            @(posedge iCLK); #1;
            case (rdy_mode)
                0:       iRD_READY = 1'b1;
                1:       iRD_READY = ~iRD_READY;
                default: iRD_READY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded 80000 cycles, required to finish earlier");
        $fatal(1);
    end

    task automatic start_cmd(input logic we, input logic rg, input logic [15:0] addr,
                             input logic [7:0] len, input logic [15:0] d0);
        logic [15:0] d;
        acc_t e;
        int k;
        if (rg) begin
            e = '{a: addr[1:0], d: d0, we: we};
            exp_acc.push_back(e);
            if (we) begin
                wd_q.push_back(d0);
                case (addr[1:0])
                    2'd0: m_addr = m_addr + 16'd2;
                    2'd1: m_mbox = d0;
                    2'd2: m_addr = d0;
                    default: ;
                endcase
            end else begin
                case (addr[1:0])
                    2'd0: begin exp_rd.push_back(mem_word(m_addr)); m_addr = m_addr + 16'd2; end
                    2'd1: exp_rd.push_back(m_mbox);
                    2'd2: exp_rd.push_back(m_addr);
                    default: exp_rd.push_back(16'h8001);
                endcase
            end
        end else begin
            e = '{a: 2'd2, d: addr, we: 1'b1};
            exp_acc.push_back(e);
            m_addr = addr;
            for (int i = 0; i <= int'(len); i++) begin
                d = d0 ^ 16'(i * 977);
                if (we) begin
                    e = '{a: 2'd0, d: d, we: 1'b1};
                    wd_q.push_back(d);
                end else begin
                    e = '{a: 2'd0, d: 16'h0, we: 1'b0};
                    exp_rd.push_back(mem_word(m_addr));
                end
                exp_acc.push_back(e);
                m_addr = m_addr + 16'd2;
            end
        end
        @(posedge iCLK); #1;
        iCMD_VALID = 1'b1; iCMD_WE = we; iCMD_REG = rg; iCMD_ADDR = addr; iCMD_LEN = len;
        k = 0;
        do begin
            @(negedge iCLK);
            k++;
        end while (!oCMD_READY && k < 200);
        if (!oCMD_READY) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_accept_timeout: waited %0d cycles, required ready within 200", k);
        end
        @(posedge iCLK); #1;
        iCMD_VALID = 1'b0;
        iCMD_ADDR  = 16'($urandom);
        iCMD_LEN   = 8'($urandom);
        iCMD_REG   = 1'($urandom_range(0, 1));
        iCMD_WE    = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(output int lat);
        int k;
        k = 0;
        forever begin
            @(negedge iCLK);
            k++;
            if (oCMD_READY) break;
            chk("busy_during_cmd", 32'(oBUSY), 32'd1);
            if (k > 6000) begin
                n_checks++; n_fail++;
                $display("FAIL idle_timeout: waited %0d cycles, required <= 6000", k);
                break;
            end
        end
        lat = k;
        chk("busy_in_idle", 32'(oBUSY), 32'd0);
        chk("acc_outstanding", 32'(exp_acc.size()), 32'd0);
        chk("rd_outstanding", 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin
        int          lat, k;
        logic [15:0] save_addr;
        logic        ip, ex;
        iRST = 1'b1;
        iCMD_VALID = 1'b0; iCMD_WE = 1'b0; iCMD_REG = 1'b0; iCMD_ADDR = 16'h0; iCMD_LEN = 8'h0;
        iIRQ_CLR = 1'b0; iHPI_INT = 1'b0;
        repeat (3) @(negedge iCLK);
        chk("rst_cs_n", 32'(oHPI_CS_N), 32'd1);
        chk("rst_wr_n", 32'(oHPI_WR_N), 32'd1);
        chk("rst_rd_n", 32'(oHPI_RD_N), 32'd1);
        chk("rst_hpi_addr", 32'(oHPI_ADDR), 32'd0);
        chk("rst_hpi_data", oHPI_DATA, 32'd0);
        chk("rst_cmd_ready", 32'(oCMD_READY), 32'd0);
        chk("rst_wd_ready", 32'(oWD_READY), 32'd0);
        chk("rst_rd_valid", 32'(oRD_VALID), 32'd0);
        chk("rst_rd_data", 32'(oRD_DATA), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_irq", 32'(oIRQ), 32'd0);
        @(posedge iCLK); #1; iRST = 1'b0;
        @(negedge iCLK);
        chk("ready_after_reset", 32'(oCMD_READY), 32'd1);

        // Abort a write mid-strobe with an asynchronous reset.
        save_addr = m_addr;
        start_cmd(1'b1, 1'b0, 16'h3000, 8'd0, 16'h1111);
        k = 0;
        while (oHPI_CS_N && k < 50) begin @(negedge iCLK); k++; end
        chk("strobe_seen_before_abort", 32'(oHPI_CS_N), 32'd0);
        #2 iRST = 1'b1;
        #1;
        chk("abort_cs_n", 32'(oHPI_CS_N), 32'd1);
        chk("abort_wr_n", 32'(oHPI_WR_N), 32'd1);
        chk("abort_rd_n", 32'(oHPI_RD_N), 32'd1);
        chk("abort_busy", 32'(oBUSY), 32'd0);
        exp_acc.delete(); exp_rd.delete(); wd_q.delete();
        m_addr = save_addr;
        repeat (2) @(negedge iCLK);
        chk("abort_cmd_ready_in_rst", 32'(oCMD_READY), 32'd0);
        @(posedge iCLK); #1; iRST = 1'b0;
        @(negedge iCLK);
        chk("abort_ready_after", 32'(oCMD_READY), 32'd1);
        repeat (25) begin
            @(negedge iCLK);
            chk("no_strobe_after_abort", 32'(oHPI_CS_N), 32'd1);
        end

        // Single memory write, data ready ahead of time.
        gap_mode = 1'b0; rdy_mode = 0;
        start_cmd(1'b1, 1'b0, 16'h1000, 8'd0, 16'hA5C3);
        wait_idle(lat);
        chk("single_write_latency", 32'(lat), 32'd17);

        // Read burst of four words with a toggling sink.
        rdy_mode = 1;
        start_cmd(1'b0, 1'b0, 16'h2000, 8'd3, 16'h0);
        wait_idle(lat);

        // Register accesses: status read, mailbox write/read, address read.
        rdy_mode = 0;
        start_cmd(1'b0, 1'b1, 16'h0003, 8'd77, 16'h0);
        wait_idle(lat);
        start_cmd(1'b1, 1'b1, 16'h0001, 8'd5, 16'hBEEF);
        wait_idle(lat);
        start_cmd(1'b0, 1'b1, 16'h0001, 8'd0, 16'h0);
        wait_idle(lat);
        start_cmd(1'b0, 1'b1, 16'h0002, 8'd0, 16'h0);
        wait_idle(lat);

        // Full 256-word write burst with gapped data; a second command must be refused.
        gap_mode = 1'b1;
        start_cmd(1'b1, 1'b0, 16'h4000, 8'd255, 16'h5A00);
        @(posedge iCLK); #1;
        iCMD_VALID = 1'b1; iCMD_WE = 1'b0; iCMD_REG = 1'b1; iCMD_ADDR = 16'h0003;
        repeat (40) begin
            @(negedge iCLK);
            chk("refuse_cmd_ready", 32'(oCMD_READY), 32'd0);
        end
        @(posedge iCLK); #1; iCMD_VALID = 1'b0;
        wait_idle(lat);
        repeat (20) begin
            @(negedge iCLK);
            chk("quiet_after_burst", 32'(oHPI_CS_N), 32'd1);
        end

        // Randomised commands.
        for (int n = 0; n < 14; n++) begin
            gap_mode = 1'($urandom_range(0, 1));
            rdy_mode = int'($urandom_range(0, 2));
            start_cmd(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                      16'($urandom) & 16'hFFFE, 8'($urandom_range(0, 9)), 16'($urandom));
            wait_idle(lat);
        end

        // Interrupt path.
        ip = 1'b0; ex = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge iCLK); #1;
            if (c < 12) begin
                iHPI_INT = (c == 2);
                iIRQ_CLR = (c == 8);
            end else begin
                iHPI_INT = ($urandom_range(0, 3) == 0);
                iIRQ_CLR = ($urandom_range(0, 4) == 0);
            end
            @(negedge iCLK);
            chk("irq", 32'(oIRQ), 32'(ex));
`ifdef HPI_IRQ_LATCH_EN
            if (iHPI_INT && !ip) ex = 1'b1;
            else if (iIRQ_CLR) ex = 1'b0;
`else
            ex = iHPI_INT;
`endif
            ip = iHPI_INT;
        end
        @(posedge iCLK); #1; iHPI_INT = 1'b0; iIRQ_CLR = 1'b0;

        repeat (10) @(negedge iCLK);
        chk("final_acc_queue", 32'(exp_acc.size()), 32'd0);
        chk("final_rd_queue", 32'(exp_rd.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
